// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame width and sample-tick divider helper
package uart_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int osr);
        return clk_freq / (baud_rate * osr);
    endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider producing a one-clk tick every DIV clocks
module uart_tick_gen #(
    parameter int DIV = 13
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    // count 0..DIV-1 and wrap on the tick
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority vote and valid/ready holding register
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600,
    parameter int OSR       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxdata,
    output logic                 rxvalid,
    input  logic                 rxready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int DIV = calc_div(clk_freq, baud_rate, OSR);
    localparam int PW = $clog2(OSR);
    localparam logic [PW-1:0] PH_MID = PW'(OSR / 2);
    localparam logic [PW-1:0] PH_END = PW'(OSR - 1);
    logic s1, rxs, tick, vote, deliver, ferr;
    logic [1:0] win;
    state_t state, state_n;
    logic [PW-1:0] ph, ph_n;
    logic [2:0] bc, bc_n;
    logic [DATA_BITS-1:0] sr, sr_n;
    uart_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
    // the window holds the two previous tick samples; the current one completes the vote
    assign vote = (win[1] & win[0]) | (win[1] & rxs) | (win[0] & rxs);
    // synchroniser, sample window and FSM registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1    <= 1'b1;
            rxs   <= 1'b1;
            win   <= '1;
            state <= IDLE;
            ph    <= '0;
            bc    <= '0;
            sr    <= '0;
        end else begin
            s1    <= rx;
            rxs   <= s1;
            win   <= tick ? {win[0], rxs} : win;
            state <= state_n;
            ph    <= ph_n;
            bc    <= bc_n;
            sr    <= sr_n;
        end
    // frame FSM: advances only on ticks, evaluating the vote at bit centres
    always_comb begin
        state_n = state;
        ph_n    = ph;
        bc_n    = bc;
        sr_n    = sr;
        deliver = 1'b0;
        ferr    = 1'b0;
        if (tick) begin
            ph_n = ph == PH_END ? '0 : ph + 1'b1;
            case (state)
                IDLE:  if (!rxs) begin
                    ph_n    = '0;
                    state_n = START;
                end
                START: if (ph == PH_MID) begin
                    ph_n    = '0;
                    bc_n    = '0;
                    state_n = vote ? IDLE : DATA;
                end
                DATA:  if (ph == PH_END) begin
                    sr_n    = {vote, sr[DATA_BITS-1:1]};
                    bc_n    = bc + 1'b1;
                    state_n = bc == 3'd7 ? STOP : DATA;
                end
                STOP:  if (ph == PH_END) begin
                    deliver = vote;
                    ferr    = !vote;
                    state_n = vote ? IDLE : BREAK;
                end
                BREAK: state_n = rxs ? IDLE : BREAK;
                default: state_n = IDLE;
            endcase
        end
    end
    // holding register: load on delivery when free or being drained, else flag overrun
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rxdata    <= '0;
            rxvalid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= deliver && rxvalid && !rxready;
            if (deliver && (!rxvalid || rxready)) begin
                rxdata  <= sr;
                rxvalid <= 1'b1;
            end else if (rxready) begin
                rxvalid <= 1'b0;
            end
        end
endmodule
